// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ravenoc_pkg
// Brief    : Shared widths, flit/IRQ enums, CSR offsets and CSR bus structs.
// Revision : 1.0
// ============================================================================
package ravenoc_pkg;

  localparam int XWidth      = 4;
  localparam int YWidth      = 4;
  localparam int FlitTpWidth = 2;
  localparam int PktWidth    = 8;

  localparam logic [31:0] RavenocLabel = 32'h5241_564E;

  typedef enum logic [FlitTpWidth-1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef enum logic [2:0] {
    IRQ_MODE_EMPTY      = 3'd0,
    IRQ_MODE_FULL       = 3'd1,
    IRQ_MODE_THRESH     = 3'd2,
    IRQ_MODE_HEAD_PULSE = 3'd3,
    IRQ_MODE_TIMEOUT    = 3'd4
  } irq_mode_t;

  // Global register offsets relative to the CSR window base
  localparam logic [15:0] c_csr_version    = 16'h0000;
  localparam logic [15:0] c_csr_x_id       = 16'h0004;
  localparam logic [15:0] c_csr_y_id       = 16'h0008;
  localparam logic [15:0] c_csr_irq_status = 16'h000C;
  localparam logic [15:0] c_csr_pending    = 16'h0010;
  localparam logic [15:0] c_csr_glb_en     = 16'h0014;
  localparam logic [15:0] c_csr_wr_full    = 16'h0018;
  localparam logic [15:0] c_csr_vc_base    = 16'h0040;

  // Register offsets inside each 16-byte per-VC block
  localparam logic [3:0] c_vc_mode     = 4'h0;
  localparam logic [3:0] c_vc_mask     = 4'h4;
  localparam logic [3:0] c_vc_thresh   = 4'h8;
  localparam logic [3:0] c_vc_pkt_size = 4'hC;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } csr_req_t;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] rdata;
  } csr_resp_t;

endpackage
`default_nettype wire

// File: rtl/noc_csr_vc_irq.sv
`default_nettype none
// ============================================================================
// Module   : noc_csr_vc_irq
// Brief    : One virtual channel's IRQ mode registers, head-flit pending flag,
//            occupancy timeout counter and registered interrupt.
// Revision : 1.0
// ============================================================================
module noc_csr_vc_irq
  import ravenoc_pkg::*;
#(
  parameter int OCUP_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk_axi,
  input  logic                   arst_axi,
  input  logic                   glb_en,
  input  logic                   mode_we,
  input  logic [2:0]             mode_wdata,
  input  logic                   mask_we,
  input  logic                   mask_wdata,
  input  logic                   thresh_we,
  input  logic [OCUP_WIDTH-1:0]  thresh_wdata,
  input  logic                   pend_clr,
  input  logic [FlitTpWidth-1:0] f_type,
  input  logic                   empty,
  input  logic                   full,
  input  logic [OCUP_WIDTH-1:0]  ocup,
  output logic [2:0]             mode,
  output logic                   mask,
  output logic [OCUP_WIDTH-1:0]  thresh,
  output logic                   pending,
  output logic                   irq
);

  localparam int c_cmp_width = (CNT_WIDTH > OCUP_WIDTH) ? CNT_WIDTH : OCUP_WIDTH;

  irq_mode_t              r_mode;
  logic                   r_mask;
  logic [OCUP_WIDTH-1:0]  r_thresh;
  logic                   r_pending;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_head_q;
  logic                   r_irq;

  logic                   w_head;
  logic                   w_head_rise;
  logic                   w_cond;
  logic [c_cmp_width-1:0] w_cnt_ext;
  logic [c_cmp_width-1:0] w_thresh_ext;

  assign w_head       = (f_type == HEAD_FLIT) && !empty;
  assign w_head_rise  = w_head && !r_head_q;
  assign w_cnt_ext    = c_cmp_width'(r_cnt);
  assign w_thresh_ext = c_cmp_width'(r_thresh);

  always_comb begin
    w_cond = 1'b0;
    case (r_mode)
      IRQ_MODE_EMPTY:      w_cond = !empty;
      IRQ_MODE_FULL:       w_cond = full;
      IRQ_MODE_THRESH:     w_cond = (ocup >= r_thresh);
      IRQ_MODE_HEAD_PULSE: w_cond = r_pending;
      IRQ_MODE_TIMEOUT:    w_cond = (w_cnt_ext >= w_thresh_ext) && !empty;
      default:             w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      r_mode    <= IRQ_MODE_EMPTY;
      r_mask    <= 1'b1;
      r_thresh  <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_head_q  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (mode_we) r_mode <= irq_mode_t'(mode_wdata);
      if (mask_we) r_mask <= mask_wdata;
      if (thresh_we) r_thresh <= thresh_wdata;
      // A new head edge beats any clear landing in the same cycle
      r_pending <= w_head_rise | (r_pending & ~(pend_clr | mode_we));
      if (mode_we || empty) begin
        r_cnt <= '0;
      end else if (!(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      r_head_q <= w_head;
      r_irq    <= w_cond & r_mask & glb_en;
    end
  end

  assign mode    = r_mode;
  assign mask    = r_mask;
  assign thresh  = r_thresh;
  assign pending = r_pending;
  assign irq     = r_irq;

endmodule
`default_nettype wire

// File: rtl/noc_csr_irq.sv
`default_nettype none
// ============================================================================
// Module   : noc_csr_irq
// Brief    : Router CSR window with one-cycle responses and per-VC interrupts.
// Revision : 1.0
// ============================================================================
module noc_csr_irq
  import ravenoc_pkg::*;
#(
  parameter int                NUM_VC      = 4,
  parameter logic [XWidth-1:0] ROUTER_X_ID = '0,
  parameter logic [YWidth-1:0] ROUTER_Y_ID = '0,
  parameter int                OCUP_WIDTH  = 16,
  parameter int                CNT_WIDTH   = 16,
  parameter logic [15:0]       BASE_ADDR   = 16'h1000
) (
  input  logic                          clk_axi,
  input  logic                          arst_axi,
  input  logic                          req_valid_i,
  input  logic                          req_wr_i,
  input  logic [15:0]                   req_addr_i,
  input  logic [31:0]                   req_wdata_i,
  output logic                          req_ready_o,
  output logic                          resp_valid_o,
  output logic                          resp_error_o,
  output logic [31:0]                   resp_rdata_o,
  input  logic [NUM_VC*FlitTpWidth-1:0] f_type_i,
  input  logic [NUM_VC-1:0]             empty_i,
  input  logic [NUM_VC-1:0]             full_i,
  input  logic [NUM_VC*OCUP_WIDTH-1:0]  ocup_i,
  input  logic [NUM_VC*PktWidth-1:0]    pkt_size_i,
  input  logic                          wr_full_i,
  output logic [NUM_VC-1:0]             irq_vcs_o,
  output logic                          irq_trig_o
);

  csr_req_t                           w_req;
  csr_resp_t                          r_resp;
  logic                               r_glb_en;

  logic [15:0]                        w_offset;
  logic [15:0]                        w_vc_rel;
  logic [11:0]                        w_vc_idx;
  logic [3:0]                         w_vc_reg;
  logic                               w_vc_region;
  logic [NUM_VC-1:0]                  w_vc_dec;

  logic                               w_err;
  logic [31:0]                        w_rdata;
  logic                               w_glb_en_we;
  logic [NUM_VC-1:0]                  w_pend_clr;
  logic [NUM_VC-1:0]                  w_mode_we;
  logic [NUM_VC-1:0]                  w_mask_we;
  logic [NUM_VC-1:0]                  w_thresh_we;

  logic [NUM_VC-1:0][2:0]             w_mode;
  logic [NUM_VC-1:0]                  w_mask;
  logic [NUM_VC-1:0][OCUP_WIDTH-1:0]  w_thresh;
  logic [NUM_VC-1:0]                  w_pending;
  logic [NUM_VC-1:0]                  w_irq;

  assign w_req       = '{valid: req_valid_i, wr: req_wr_i, addr: req_addr_i, wdata: req_wdata_i};
  assign w_offset    = w_req.addr - BASE_ADDR;
  assign w_vc_rel    = w_offset - c_csr_vc_base;
  assign w_vc_idx    = w_vc_rel[15:4];
  assign w_vc_reg    = w_vc_rel[3:0];
  assign w_vc_region = (w_offset >= c_csr_vc_base);

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      w_vc_dec[i] = w_vc_region && (w_vc_idx == 12'(i));
    end
  end

  // Address decode: read mux, write strobes and error flag for this cycle's request
  always_comb begin
    w_err       = 1'b0;
    w_rdata     = '0;
    w_glb_en_we = 1'b0;
    w_pend_clr  = '0;
    w_mode_we   = '0;
    w_mask_we   = '0;
    w_thresh_we = '0;
    if (w_req.valid) begin
      if (w_vc_region) begin
        w_err = ~|w_vc_dec;
        for (int i = 0; i < NUM_VC; i++) begin
          if (w_vc_dec[i]) begin
            case (w_vc_reg)
              c_vc_mode: begin
                if (w_req.wr) begin
                  if (w_req.wdata > 32'(IRQ_MODE_TIMEOUT)) w_err = 1'b1;
                  else                                     w_mode_we[i] = 1'b1;
                end else begin
                  w_rdata[2:0] = w_mode[i];
                end
              end
              c_vc_mask: begin
                if (w_req.wr) w_mask_we[i] = 1'b1;
                else          w_rdata[0]   = w_mask[i];
              end
              c_vc_thresh: begin
                if (w_req.wr) w_thresh_we[i]           = 1'b1;
                else          w_rdata[OCUP_WIDTH-1:0] = w_thresh[i];
              end
              c_vc_pkt_size: begin
                if (w_req.wr) w_err                 = 1'b1;
                else          w_rdata[PktWidth-1:0] = pkt_size_i[i*PktWidth +: PktWidth];
              end
              default: w_err = 1'b1;
            endcase
          end
        end
      end else begin
        case (w_offset)
          c_csr_version: begin
            if (w_req.wr) w_err   = 1'b1;
            else          w_rdata = RavenocLabel;
          end
          c_csr_x_id: begin
            if (w_req.wr) w_err               = 1'b1;
            else          w_rdata[XWidth-1:0] = ROUTER_X_ID;
          end
          c_csr_y_id: begin
            if (w_req.wr) w_err               = 1'b1;
            else          w_rdata[YWidth-1:0] = ROUTER_Y_ID;
          end
          c_csr_irq_status: begin
            if (w_req.wr) w_err               = 1'b1;
            else          w_rdata[NUM_VC-1:0] = w_irq;
          end
          c_csr_pending: begin
            if (w_req.wr) w_pend_clr          = w_req.wdata[NUM_VC-1:0];
            else          w_rdata[NUM_VC-1:0] = w_pending;
          end
          c_csr_glb_en: begin
            if (w_req.wr) w_glb_en_we = 1'b1;
            else          w_rdata[0]  = r_glb_en;
          end
          c_csr_wr_full: begin
            if (w_req.wr) w_err      = 1'b1;
            else          w_rdata[0] = wr_full_i;
          end
          default: w_err = 1'b1;
        endcase
      end
      if (w_err) w_rdata = '0;
    end
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      r_resp   <= '0;
      r_glb_en <= 1'b1;
    end else begin
      r_resp.valid <= w_req.valid;
      r_resp.error <= w_req.valid & w_err;
      r_resp.rdata <= w_rdata;
      if (w_glb_en_we) r_glb_en <= w_req.wdata[0];
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    noc_csr_vc_irq #(
      .OCUP_WIDTH (OCUP_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_vc_irq (
      .clk_axi      (clk_axi),
      .arst_axi     (arst_axi),
      .glb_en       (r_glb_en),
      .mode_we      (w_mode_we[g]),
      .mode_wdata   (w_req.wdata[2:0]),
      .mask_we      (w_mask_we[g]),
      .mask_wdata   (w_req.wdata[0]),
      .thresh_we    (w_thresh_we[g]),
      .thresh_wdata (w_req.wdata[OCUP_WIDTH-1:0]),
      .pend_clr     (w_pend_clr[g]),
      .f_type       (f_type_i[g*FlitTpWidth +: FlitTpWidth]),
      .empty        (empty_i[g]),
      .full         (full_i[g]),
      .ocup         (ocup_i[g*OCUP_WIDTH +: OCUP_WIDTH]),
      .mode         (w_mode[g]),
      .mask         (w_mask[g]),
      .thresh       (w_thresh[g]),
      .pending      (w_pending[g]),
      .irq          (w_irq[g])
    );
  end

  assign req_ready_o  = 1'b1;
  assign resp_valid_o = r_resp.valid;
  assign resp_error_o = r_resp.error;
  assign resp_rdata_o = r_resp.rdata;
  assign irq_vcs_o    = w_irq;
  assign irq_trig_o   = |w_irq;

endmodule
`default_nettype wire
